// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255-style PPI.
// Mode 1 handshake state encodings and address codes.
package ppi_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] ADDR_PA  = 2'b00;
   localparam logic [1:0] ADDR_PB  = 2'b01;
   localparam logic [1:0] ADDR_PC  = 2'b10;
   localparam logic [1:0] ADDR_CTL = 2'b11;

   typedef enum logic [2:0] {
      IN_EMPTY  = 3'b000,
      IN_STROBE = 3'b001,
      IN_FULL   = 3'b010,
      IN_READ   = 3'b011,
      OUT_EMPTY = 3'b100,
      OUT_WRITE = 3'b101,
      OUT_FULL  = 3'b110,
      OUT_ACK   = 3'b111
   } ppi_state_t;

   function automatic logic is_in_state(ppi_state_t s);
      return (s == IN_EMPTY) || (s == IN_STROBE) ||
             (s == IN_FULL)  || (s == IN_READ);
   endfunction

endpackage

// File: rtl/ppi_edge_sync.sv
// Synchronizer for one async active-low pin.
// Emits one-cycle rise/fall pulses after the chain.
module ppi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   // Shift the pin through the chain; idle level is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         last_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = ~last_q &  sync_q[SYNC_STAGES-1];
   assign fall =  last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_mode1_handshake.sv
// 8255 Mode 1 strobed handshake for one port group.
// One FSM covers both input and output direction.
import ppi_pkg::*;

module ppi_mode1_handshake #(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              mode1_en,
   input  logic              dir_in,
   input  logic              inte,
   input  logic              port_sel,
   input  logic              RD,
   input  logic              WR,
   input  logic              STB_n,
   input  logic              ACK_n,
   input  logic [DATA_W-1:0] port_din,
   input  logic [DATA_W-1:0] bus_din,
   output logic [DATA_W-1:0] bus_dout,
   output logic [DATA_W-1:0] port_dout,
   output logic              IBF,
   output logic              OBF_n,
   output logic              INTR,
   output logic              overrun
);

   logic stb_rise, stb_fall;
   logic ack_rise, ack_fall;
   logic rd_rise_raw, rd_fall_raw;
   logic wr_rise_raw, wr_fall_raw;
   logic rd_rise, rd_fall;
   logic wr_rise, wr_fall;

   ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
      .clk(CLK), .reset(RESET), .pin(STB_n),
      .rise(stb_rise), .fall(stb_fall)
   );

   ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack (
      .clk(CLK), .reset(RESET), .pin(ACK_n),
      .rise(ack_rise), .fall(ack_fall)
   );

   ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd (
      .clk(CLK), .reset(RESET), .pin(RD),
      .rise(rd_rise_raw), .fall(rd_fall_raw)
   );

   ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr (
      .clk(CLK), .reset(RESET), .pin(WR),
      .rise(wr_rise_raw), .fall(wr_fall_raw)
   );

   assign rd_rise = rd_rise_raw & port_sel;
   assign rd_fall = rd_fall_raw & port_sel;
   assign wr_rise = wr_rise_raw & port_sel;
   assign wr_fall = wr_fall_raw & port_sel;

   ppi_state_t        state;
   logic              ibf_q;
   logic              obf_n_q;
   logic              intr_q;
   logic              overrun_q;
   logic              out_done_q;
   logic [DATA_W-1:0] in_latch;
   logic [DATA_W-1:0] out_latch;

   // Handshake FSM; out_done_q marks an ACK-completed output buffer.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IN_EMPTY;
         ibf_q      <= 1'b0;
         obf_n_q    <= 1'b1;
         intr_q     <= 1'b0;
         overrun_q  <= 1'b0;
         out_done_q <= 1'b0;
         in_latch   <= '0;
         out_latch  <= '0;
      end else if (!mode1_en ||
                   (is_in_state(state) != dir_in)) begin
         state      <= dir_in ? IN_EMPTY : OUT_EMPTY;
         ibf_q      <= 1'b0;
         obf_n_q    <= 1'b1;
         intr_q     <= 1'b0;
         overrun_q  <= 1'b0;
         out_done_q <= 1'b0;
      end else begin
         intr_q <= inte &
                   ((state == IN_FULL) |
                    ((state == OUT_EMPTY) & out_done_q));
         unique case (state)
            IN_EMPTY: begin
               if (stb_fall) begin
                  state    <= IN_STROBE;
                  in_latch <= port_din;
                  ibf_q    <= 1'b1;
               end
            end
            IN_STROBE: begin
               if (stb_rise) begin
                  state  <= IN_FULL;
                  intr_q <= inte;
               end
            end
            IN_FULL: begin
               if (stb_fall) overrun_q <= 1'b1;
               if (rd_fall) begin
                  state  <= IN_READ;
                  intr_q <= 1'b0;
               end
            end
            IN_READ: begin
               if (rd_rise) begin
                  overrun_q <= 1'b0;
                  ibf_q     <= 1'b0;
                  state     <= IN_EMPTY;
                  if (stb_fall) begin
                     state    <= IN_STROBE;
                     in_latch <= port_din;
                     ibf_q    <= 1'b1;
                  end
               end else if (stb_fall) begin
                  overrun_q <= 1'b1;
               end
            end
            OUT_EMPTY: begin
               if (wr_fall) begin
                  state      <= OUT_WRITE;
                  intr_q     <= 1'b0;
                  out_done_q <= 1'b0;
               end
            end
            OUT_WRITE: begin
               if (wr_rise) begin
                  state     <= OUT_FULL;
                  out_latch <= bus_din;
                  obf_n_q   <= 1'b0;
               end
            end
            OUT_FULL: begin
               if (ack_fall) begin
                  state   <= OUT_ACK;
                  obf_n_q <= 1'b1;
               end
               if (wr_fall) begin
                  state   <= OUT_WRITE;
                  obf_n_q <= 1'b0;
                  intr_q  <= 1'b0;
               end
            end
            OUT_ACK: begin
               if (ack_rise) begin
                  state      <= OUT_EMPTY;
                  intr_q     <= inte;
                  out_done_q <= 1'b1;
               end
               if (wr_fall) begin
                  state  <= OUT_WRITE;
                  intr_q <= 1'b0;
               end
            end
            default: state <= IN_EMPTY;
         endcase
      end
   end

   assign bus_dout  = in_latch;
   assign port_dout = out_latch;
   assign IBF       = ibf_q;
   assign OBF_n     = obf_n_q;
   assign INTR      = intr_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ppi_mode1_handshake.sv
// Bench for ppi_mode1_handshake: directed + random.
// Expected values come from a protocol-level model.
module tb_ppi_mode1_handshake;

   localparam int SYNC = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       mode1_en = 1'b1;
   logic       dir_in = 1'b1;
   logic       inte = 1'b1;
   logic       port_sel = 1'b1;
   logic       RD = 1'b1;
   logic       WR = 1'b1;
   logic       STB_n = 1'b1;
   logic       ACK_n = 1'b1;
   logic [7:0] port_din = '0;
   logic [7:0] bus_din = '0;
   logic [7:0] bus_dout;
   logic [7:0] port_dout;
   logic       IBF;
   logic       OBF_n;
   logic       INTR;
   logic       overrun;

   ppi_mode1_handshake #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
      .CLK(CLK), .RESET(RESET), .mode1_en(mode1_en),
      .dir_in(dir_in), .inte(inte), .port_sel(port_sel),
      .RD(RD), .WR(WR), .STB_n(STB_n), .ACK_n(ACK_n),
      .port_din(port_din), .bus_din(bus_din),
      .bus_dout(bus_dout), .port_dout(port_dout),
      .IBF(IBF), .OBF_n(OBF_n), .INTR(INTR), .overrun(overrun)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // protocol-level model of the port group
   logic       m_dir = 1'b1;
   logic       m_inte = 1'b1;
   logic       m_ibf, m_obf_n, m_overrun;
   logic [7:0] m_in, m_out;
   logic       m_stb_taken, m_reading;
   logic       m_writing, m_acking, m_done;

   function automatic logic m_intr();
      if (m_dir)
         return m_inte & m_ibf & ~m_stb_taken & ~m_reading;
      return m_inte & m_done & ~m_writing;
   endfunction

   task automatic m_abort();
      m_ibf = 0; m_obf_n = 1; m_overrun = 0;
      m_stb_taken = 0; m_reading = 0;
      m_writing = 0; m_acking = 0; m_done = 0;
   endtask

   task automatic m_reset();
      m_abort();
      m_in = '0; m_out = '0;
   endtask

   task automatic m_stb(input logic v);
      if (!m_dir) return;
      if (!v) begin
         if (m_ibf) m_overrun = 1;
         else begin
            m_in = port_din; m_ibf = 1; m_stb_taken = 1;
         end
      end else m_stb_taken = 0;
   endtask

   task automatic m_rd(input logic v);
      if (!m_dir || !port_sel) return;
      if (!v) begin
         if (m_ibf && !m_stb_taken && !m_reading) m_reading = 1;
      end else if (m_reading) begin
         m_reading = 0; m_ibf = 0; m_overrun = 0;
      end
   endtask

   task automatic m_wr(input logic v);
      if (m_dir || !port_sel) return;
      if (!v) begin
         m_writing = 1; m_acking = 0; m_done = 0;
      end else if (m_writing) begin
         m_writing = 0; m_out = bus_din; m_obf_n = 0;
      end
   endtask

   task automatic m_ack(input logic v);
      if (m_dir) return;
      if (!v) begin
         if (!m_obf_n && !m_writing) begin
            m_obf_n = 1; m_acking = 1;
         end
      end else if (m_acking) begin
         m_acking = 0; m_done = 1;
      end
   endtask

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ibf"},  32'(IBF),       32'(m_ibf));
      check({tag, ".obf"},  32'(OBF_n),     32'(m_obf_n));
      check({tag, ".intr"}, 32'(INTR),      32'(m_intr()));
      check({tag, ".ovr"},  32'(overrun),   32'(m_overrun));
      check({tag, ".bus"},  32'(bus_dout),  32'(m_in));
      check({tag, ".port"}, 32'(port_dout), 32'(m_out));
   endtask

   task automatic settle(input int extra);
      repeat (SYNC + 2 + extra) @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int pin, input logic v, input string tag);
      @(posedge CLK); #1;
      case (pin)
         0: begin STB_n = v; m_stb(v); end
         1: begin RD    = v; m_rd(v);  end
         2: begin WR    = v; m_wr(v);  end
         default: begin ACK_n = v; m_ack(v); end
      endcase
      settle(int'($urandom_range(0, 2)));
      check_all(tag);
   endtask

   task automatic pulse(input int pin, input string tag);
      drive(pin, 1'b0, {tag, "_f"});
      drive(pin, 1'b1, {tag, "_r"});
   endtask

   task automatic set_dir(input logic v);
      @(posedge CLK); #1;
      dir_in = v;
      if (v != m_dir) m_abort();
      m_dir = v;
      settle(0);
      check_all("dir");
   endtask

   task automatic set_inte(input logic v);
      @(posedge CLK); #1;
      inte = v; m_inte = v;
      repeat (2) @(posedge CLK);
      #1;
      check_all("inte");
   endtask

   task automatic do_reset(input string tag);
      @(posedge CLK); #1;
      RESET = 1;
      @(posedge CLK); #1;
      m_reset();
      check_all(tag);
      RESET = 0;
      settle(0);
      check_all({tag, "_post"});
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge CLK);
      #1 RESET = 0;
      @(posedge CLK); #1;
      check_all("reset");

      // input path: IBF latency and strobe/read sequence
      port_din = 8'hA5;
      @(posedge CLK); #1;
      STB_n = 0;
      repeat (2) @(posedge CLK);
      #1 check("ibf_lat2", 32'(IBF), 32'd0);
      @(posedge CLK); #1;
      m_stb(0);
      check("ibf_lat3", 32'(IBF), 32'd1);
      settle(0);
      check_all("in_stb_f");
      drive(0, 1'b1, "in_stb_r");
      pulse(1, "in_rd");

      // overrun, then ignored read, then real read
      port_din = 8'hA5;
      pulse(0, "ov_stb1");
      port_din = 8'hFF;
      pulse(0, "ov_stb2");
      port_sel = 0;
      pulse(1, "ov_rd_nosel");
      port_sel = 1;
      pulse(1, "ov_rd");

      // interrupts disabled: IBF still toggles
      set_inte(0);
      port_din = 8'h5A;
      pulse(0, "noint_stb");
      pulse(1, "noint_rd");
      set_inte(1);

      // read completion and new strobe on the same edge
      pulse(0, "sc_stb");
      drive(1, 1'b0, "sc_rd_f");
      @(posedge CLK); #1;
      port_din = 8'hC3;
      RD = 1; STB_n = 0;
      m_rd(1); m_stb(0);
      settle(0);
      check_all("sc_both");
      drive(0, 1'b1, "sc_stb_r");
      pulse(1, "sc_rd2");

      // output path
      set_dir(0);
      bus_din = 8'h3C;
      pulse(2, "out_wr");
      pulse(3, "out_ack");
      port_sel = 0;
      bus_din = 8'h99;
      pulse(2, "out_wr_nosel");
      port_sel = 1;
      set_inte(0);
      set_inte(1);
      pulse(2, "out_wr2");
      bus_din = 8'h77;
      pulse(2, "out_overwr");
      pulse(3, "out_ack2");

      // reset in OUT_FULL and IN_FULL
      bus_din = 8'h42;
      pulse(2, "rf_wr");
      do_reset("rst_ofull");
      set_dir(1);
      port_din = 8'h81;
      pulse(0, "rf_stb");
      do_reset("rst_ifull");

      // mode disable keeps latches
      port_din = 8'h24;
      pulse(0, "m1_stb");
      @(posedge CLK); #1;
      mode1_en = 0;
      m_abort();
      settle(0);
      check_all("m1_off");
      mode1_en = 1;
      settle(0);
      check_all("m1_on");

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               if (!m_dir) set_dir(1);
               port_din = 8'($urandom);
               pulse(0, "r_stb");
               if ($urandom_range(0, 1) == 1) begin
                  port_din = 8'($urandom);
                  pulse(0, "r_stb2");
               end
               port_sel = ($urandom_range(0, 3) != 0);
               pulse(1, "r_rd");
               port_sel = 1;
            end
            1: begin
               if (m_dir) set_dir(0);
               bus_din = 8'($urandom);
               port_sel = ($urandom_range(0, 3) != 0);
               pulse(2, "r_wr");
               port_sel = 1;
               if ($urandom_range(0, 1) == 1) begin
                  bus_din = 8'($urandom);
                  pulse(2, "r_wr2");
               end
               pulse(3, "r_ack");
            end
            2: set_inte(1'($urandom_range(0, 1)));
            3: begin
               port_sel = 1'($urandom_range(0, 1));
               pulse(1, "r_rd_only");
               port_sel = 1;
            end
            default: begin
               if (m_dir) pulse(3, "r_ack_in");
               else pulse(0, "r_stb_out");
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
